// File: rtl/pc_sequencer.sv
// Multicycle fetch/decode/PC-update sequencer: resolves branches, jumps and jr locally,
// hands everything else to the main controller, and counts retired instructions.
module pc_sequencer #(
   parameter int MEM_WAIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        hold,
   input  logic        exec_done,
   output logic [1:0]  pc_source,
   output logic        pc_write,
   output logic        ir_write,
   output logic        mem_read,
   output logic [1:0]  alu_sel,
   output logic        aluout_write,
   output logic        ra_write,
   output logic        exec_req,
   output logic [2:0]  state,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_BRANCH = 3'd3,
      S_JUMP   = 3'd4,
      S_JR     = 3'd5,
      S_EXEC   = 3'd6
   } state_t;

   localparam logic [3:0] WLAST = 4'(MEM_WAIT - 1);

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [5:0]  opc_q, opc_d, fn_q, fn_d;
   logic [31:0] retired_q, retired_d;
   logic        retire;
   logic        pc_wr, ir_wr, ao_wr, ra_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RESET;
         wcnt_q    <= 4'd0;
         opc_q     <= 6'd0;
         fn_q      <= 6'd0;
         retired_q <= 32'd0;
      end else if (!hold) begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         opc_q     <= opc_d;
         fn_q      <= fn_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      opc_d     = opc_q;
      fn_d      = fn_q;
      retire    = 1'b0;
      pc_source = 2'b00;
      alu_sel   = 2'b00;
      mem_read  = 1'b0;
      exec_req  = 1'b0;
      pc_wr     = 1'b0;
      ir_wr     = 1'b0;
      ao_wr     = 1'b0;
      ra_wr     = 1'b0;
      case (state_q)
         S_RESET: begin
            wcnt_d  = 4'd0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_read = 1'b1;
            if (wcnt_q == WLAST) begin
               ir_wr   = 1'b1;
               pc_wr   = 1'b1;
               wcnt_d  = 4'd0;
               state_d = S_DECODE;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut while the opcode is decoded.
            alu_sel = 2'b01;
            ao_wr   = 1'b1;
            opc_d   = opcode;
            fn_d    = funct;
            if (opcode == 6'h04 || opcode == 6'h05)      state_d = S_BRANCH;
            else if (opcode == 6'h02 || opcode == 6'h03) state_d = S_JUMP;
            else if (opcode == 6'h00 && funct == 6'h08)  state_d = S_JR;
            else                                         state_d = S_EXEC;
         end
         S_BRANCH: begin
            alu_sel   = 2'b10;
            pc_source = 2'b01;
            pc_wr     = ((opc_q == 6'h04) & zero) | ((opc_q == 6'h05) & ~zero);
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_source = 2'b10;
            pc_wr     = 1'b1;
            ra_wr     = (opc_q == 6'h03);
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JR: begin
            alu_sel = 2'b11;
            pc_wr   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_EXEC: begin
            exec_req = 1'b1;
            if (exec_done) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_RESET;
      endcase
   end

   assign retired_d = retired_q + {31'd0, retire};

   // Register-load strobes are suppressed during a stall; mux selects keep their decode.
   assign pc_write     = pc_wr & ~hold;
   assign ir_write     = ir_wr & ~hold;
   assign aluout_write = ao_wr & ~hold;
   assign ra_write     = ra_wr & ~hold;
   assign state        = state_q;
   assign retired      = retired_q;

endmodule
